// File: rtl/timekeeper_pkg.sv
// Shared types and constants for the timekeeper: operating modes, keypad codes
// and time-field limits.
package timekeeper_pkg;

    localparam logic [1:0] MODE_CLOCK = 2'd0;
    localparam logic [1:0] MODE_SET   = 2'd1;
    localparam logic [1:0] MODE_TIMER = 2'd2;

    typedef enum logic [1:0] {
        CLOCK = MODE_CLOCK,
        SET   = MODE_SET,
        TIMER = MODE_TIMER
    } mode_t;

    localparam logic [4:0] KEY_NULL = 5'd0;
    localparam logic [4:0] KEY_MODE = 5'd1;
    localparam logic [4:0] KEY_HOUR = 5'd2;
    localparam logic [4:0] KEY_MIN  = 5'd3;
    localparam logic [4:0] KEY_SEC  = 5'd4;
    localparam logic [4:0] KEY_ACK  = 5'd5;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            CLOCK:   return SET;
            SET:     return TIMER;
            default: return CLOCK;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Seconds prescaler: counts mclk cycles while run is high and emits a one-cycle
// registered tick on every wrap from CLK_HZ-1 back to 0.
module tick_gen #(
    parameter int CLK_HZ = 32000000
) (
    input  logic mclk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (run) begin
                if (cnt == CNT_MAX) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/timekeeper.sv
// Keypad-driven wall clock with SET and countdown TIMER modes; time fields, the
// mode FSM and key edge detection live here, the seconds prescaler in tick_gen.
module timekeeper
    import timekeeper_pkg::*;
#(
    parameter int CLK_HZ = 32000000,
    parameter int HOURS  = 24
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] key_code,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] sec,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       alarm
);

    localparam logic [4:0] HOUR_MAX = 5'(HOURS - 1);

    mode_t      mode_q;
    logic       in_set;
    logic [4:0] key_q;
    logic       key_armed;
    logic       key_evt;
    logic       mode_key;
    logic       edit_key;
    logic       tick_ok;
    logic       at_zero;
    logic       pre_rst;

    // The prescaler sits in reset for the whole of SET so it is held at 0 and
    // cannot tick; in_set is a flop, so this reset term is glitch-free.
    assign pre_rst = rst | in_set;

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .mclk (mclk),
        .rst  (pre_rst),
        .run  (en & ~in_set),
        .tick (sec_tick)
    );

    assign mode = mode_q;

    // key_armed stays low after reset until a released keypad is seen, so a key
    // held through reset release never counts as a press.
    always_comb begin
        key_evt  = (key_code != KEY_NULL) && (key_q == KEY_NULL) && key_armed;
        mode_key = key_evt && (key_code == KEY_MODE);
        edit_key = key_evt && (mode_q == SET) &&
                   ((key_code == KEY_HOUR) || (key_code == KEY_MIN) || (key_code == KEY_SEC));
        tick_ok  = sec_tick && !mode_key && !edit_key;
        at_zero  = (hour == 5'd0) && (minute == 6'd0) && (sec == 6'd0);
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            key_q     <= KEY_NULL;
            key_armed <= 1'b0;
        end else begin
            key_q <= key_code;
            if (key_code == KEY_NULL)
                key_armed <= 1'b1;
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            mode_q <= CLOCK;
            in_set <= 1'b0;
            hour   <= 5'd0;
            minute <= 6'd0;
            sec    <= 6'd0;
            alarm  <= 1'b0;
        end else begin
            if (mode_key) begin
                mode_q <= next_mode(mode_q);
                in_set <= (next_mode(mode_q) == SET);
                if (mode_q == TIMER)
                    alarm <= 1'b0;
            end else if (edit_key) begin
                case (key_code)
                    KEY_HOUR: hour   <= (hour == HOUR_MAX) ? 5'd0 : hour + 5'd1;
                    KEY_MIN:  minute <= (minute == MIN_MAX) ? 6'd0 : minute + 6'd1;
                    default:  sec    <= 6'd0;
                endcase
            end else if (tick_ok && (mode_q == CLOCK)) begin
                if (sec == SEC_MAX) begin
                    sec <= 6'd0;
                    if (minute == MIN_MAX) begin
                        minute <= 6'd0;
                        hour   <= (hour == HOUR_MAX) ? 5'd0 : hour + 5'd1;
                    end else begin
                        minute <= minute + 6'd1;
                    end
                end else begin
                    sec <= sec + 6'd1;
                end
            end else if (tick_ok && (mode_q == TIMER) && !at_zero) begin
                // Countdown parks at 00:00:00; the tick that lands there raises alarm.
                if (sec == 6'd0) begin
                    sec <= SEC_MAX;
                    if (minute == 6'd0) begin
                        minute <= MIN_MAX;
                        hour   <= hour - 5'd1;
                    end else begin
                        minute <= minute - 6'd1;
                    end
                end else begin
                    sec <= sec - 6'd1;
                end
                if ((hour == 5'd0) && (minute == 6'd0) && (sec == 6'd1))
                    alarm <= 1'b1;
            end

            if (key_evt && (key_code == KEY_ACK))
                alarm <= 1'b0;
        end
    end

endmodule

// File: tb/tb_timekeeper.sv
// Directed bench for timekeeper at CLK_HZ=4, with a 24-hour and a 12-hour instance
// sharing stimulus; expected states go through a scoreboard queue.
module tb_timekeeper;
    import timekeeper_pkg::*;

    logic       mclk = 1'b0;
    logic       rst;
    logic       en;
    logic [4:0] key_code;

    logic [4:0] hour, hour_b;
    logic [5:0] minute, minute_b;
    logic [5:0] sec, sec_b;
    logic [1:0] mode, mode_b;
    logic       sec_tick, sec_tick_b;
    logic       alarm, alarm_b;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [19:0] val;
    } exp_t;

    exp_t sb[$];

    timekeeper #(.CLK_HZ(4), .HOURS(24)) dut (
        .mclk(mclk), .rst(rst), .en(en), .key_code(key_code),
        .hour(hour), .minute(minute), .sec(sec), .mode(mode),
        .sec_tick(sec_tick), .alarm(alarm)
    );

    timekeeper #(.CLK_HZ(4), .HOURS(12)) dut12 (
        .mclk(mclk), .rst(rst), .en(en), .key_code(key_code),
        .hour(hour_b), .minute(minute_b), .sec(sec_b), .mode(mode_b),
        .sec_tick(sec_tick_b), .alarm(alarm_b)
    );

    always #5 mclk = ~mclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic press(input logic [4:0] code);
        key_code = code;
        cyc(1);
        key_code = KEY_NULL;
        cyc(1);
    endtask

    task automatic push(input string tag, input int h, input int m, input int s,
                        input int md, input int al);
        exp_t e;
        e.tag = tag;
        e.val = {5'(h), 6'(m), 6'(s), 2'(md), 1'(al)};
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        logic [19:0] obs;
        e = sb.pop_front();
        obs = {hour, minute, sec, mode, alarm};
        vectors++;
        assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s: observed %0d:%0d:%0d mode=%0d alarm=%0d required %0d:%0d:%0d mode=%0d alarm=%0d",
                   e.tag, obs[19:15], obs[14:9], obs[8:3], obs[2:1], obs[0],
                   e.val[19:15], e.val[14:9], e.val[8:3], e.val[2:1], e.val[0]);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        int k = 0;
        while (sec_tick !== 1'b1 && k < 20) begin
            cyc(1);
            k++;
        end
        vectors++;
        assert (k < 20) else begin
            miscompares++;
            $error("FAIL tick_timeout: observed no sec_tick within %0d cycles required one", k);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            wait_tick();
            cyc(1);
        end
    endtask

    initial begin
        int ticks_seen;
        rst = 1'b1;
        en = 1'b0;
        key_code = KEY_NULL;

        push("reset_state", 0, 0, 0, 0, 0);
        cyc(3);
        pop_check();
        chk("reset_tick", {7'd0, sec_tick}, 8'd0);
        rst = 1'b0;
        cyc(1);

        // Build 05:06:00 in SET, walk back to CLOCK with the prescaler frozen.
        push("enter_set", 0, 0, 0, 1, 0);
        press(KEY_MODE);
        pop_check();
        repeat (5) press(KEY_HOUR);
        repeat (6) press(KEY_MIN);
        push("set_050600", 5, 6, 0, 1, 0);
        pop_check();
        press(KEY_MODE);
        push("back_clock", 5, 6, 0, 0, 0);
        press(KEY_MODE);
        pop_check();

        en = 1'b1;
        push("count_050607", 5, 6, 7, 0, 0);
        tick_n(7);
        pop_check();

        // Asynchronous reset mid-count, key 1 held through release.
        #2;
        rst = 1'b1;
        key_code = KEY_MODE;
        push("async_rst", 0, 0, 0, 0, 0);
        #1;
        pop_check();
        chk("async_rst_tick", {7'd0, sec_tick}, 8'd0);
        push("rst_held", 0, 0, 0, 0, 0);
        cyc(2);
        pop_check();
        en = 1'b0;
        rst = 1'b0;
        push("rst_release_held_key", 0, 0, 0, 0, 0);
        cyc(4);
        pop_check();
        key_code = KEY_NULL;
        push("key_released", 0, 0, 0, 0, 0);
        cyc(1);
        pop_check();
        push("press_after_release", 0, 0, 0, 1, 0);
        press(KEY_MODE);
        pop_check();

        // Key 2 held 50 cycles in SET: a single increment, no ticks.
        en = 1'b1;
        ticks_seen = 0;
        key_code = KEY_HOUR;
        repeat (50) begin
            cyc(1);
            if (sec_tick === 1'b1) ticks_seen++;
        end
        key_code = KEY_NULL;
        cyc(1);
        chk("set_no_tick", 8'(ticks_seen), 8'd0);
        push("hold_hour_once", 1, 0, 0, 1, 0);
        pop_check();
        repeat (59) press(KEY_MIN);
        push("min_59", 1, 59, 0, 1, 0);
        pop_check();
        push("min_wrap_no_carry", 1, 0, 0, 1, 0);
        press(KEY_MIN);
        pop_check();

        repeat (22) press(KEY_HOUR);
        chk("b_hour_wrap_set", {3'd0, hour_b}, 8'd11);
        repeat (59) press(KEY_MIN);
        en = 1'b0;
        press(KEY_MODE);
        push("clock_235900", 23, 59, 0, 0, 0);
        press(KEY_MODE);
        pop_check();

        en = 1'b1;
        push("clock_235959", 23, 59, 59, 0, 0);
        tick_n(59);
        pop_check();
        chk("b_hour_1159", {3'd0, hour_b}, 8'd11);
        chk("b_sec_1159", {2'd0, sec_b}, 8'd59);
        push("rollover_24", 0, 0, 0, 0, 0);
        tick_n(1);
        pop_check();
        chk("rollover_12", {hour_b, minute_b[2:0]}, 8'd0);
        chk("rollover_12_min_sec", {minute_b[5:3], 5'(sec_b)}, 8'd0);

        // Enable gating holds the prescaler phase.
        push("before_freeze", 0, 0, 2, 0, 0);
        tick_n(2);
        pop_check();
        en = 1'b0;
        ticks_seen = 0;
        repeat (20) begin
            cyc(1);
            if (sec_tick === 1'b1) ticks_seen++;
        end
        chk("freeze_no_tick", 8'(ticks_seen), 8'd0);
        push("freeze_time", 0, 0, 2, 0, 0);
        pop_check();
        en = 1'b1;
        cyc(2);
        chk("resume_phase_early", {7'd0, sec_tick}, 8'd0);
        cyc(1);
        chk("resume_phase_tick", {7'd0, sec_tick}, 8'd1);
        push("resume_sec3", 0, 0, 3, 0, 0);
        cyc(1);
        pop_check();
        cyc(2);
        chk("period_early", {7'd0, sec_tick}, 8'd0);
        cyc(1);
        chk("period_tick", {7'd0, sec_tick}, 8'd1);
        push("resume_sec4", 0, 0, 4, 0, 0);
        cyc(1);
        pop_check();

        // Edit keys and unknown codes ignored outside SET.
        en = 1'b0;
        push("keys_ignored_clock", 0, 0, 4, 0, 0);
        press(KEY_HOUR);
        press(KEY_MIN);
        press(KEY_SEC);
        press(5'd7);
        press(5'd16);
        pop_check();

        // Key 1 coincident with a tick: mode changes, tick dropped.
        en = 1'b1;
        push("clock_000010", 0, 0, 10, 0, 0);
        tick_n(6);
        pop_check();
        wait_tick();
        key_code = KEY_MODE;
        push("key_beats_tick", 0, 0, 10, 1, 0);
        cyc(1);
        pop_check();
        key_code = KEY_NULL;
        cyc(1);
        push("clear_sec", 0, 0, 0, 1, 0);
        press(KEY_SEC);
        pop_check();
        press(KEY_MIN);

        // Countdown from 00:01:00.
        push("enter_timer", 0, 1, 0, 2, 0);
        press(KEY_MODE);
        pop_check();
        push("timer_000001", 0, 0, 1, 2, 0);
        tick_n(59);
        pop_check();
        push("timer_expire", 0, 0, 0, 2, 1);
        tick_n(1);
        pop_check();
        push("timer_parked", 0, 0, 0, 2, 1);
        tick_n(5);
        pop_check();
        push("alarm_ack", 0, 0, 0, 2, 0);
        press(KEY_ACK);
        pop_check();

        // Entering TIMER at zero does not raise alarm.
        en = 1'b0;
        press(KEY_MODE);
        press(KEY_MODE);
        push("timer_at_zero", 0, 0, 0, 2, 0);
        press(KEY_MODE);
        pop_check();
        press(KEY_MODE);
        en = 1'b1;
        tick_n(2);
        en = 1'b0;
        press(KEY_MODE);
        push("timer_000002", 0, 0, 2, 2, 0);
        press(KEY_MODE);
        pop_check();
        en = 1'b1;
        push("timer_expire2", 0, 0, 0, 2, 1);
        tick_n(2);
        pop_check();
        en = 1'b0;
        push("leave_timer_clears", 0, 0, 0, 0, 0);
        press(KEY_MODE);
        pop_check();

        // Hour borrow, then reset mid-countdown.
        press(KEY_MODE);
        press(KEY_HOUR);
        press(KEY_MODE);
        en = 1'b1;
        push("hour_borrow", 0, 59, 57, 2, 0);
        tick_n(3);
        pop_check();
        #2;
        rst = 1'b1;
        push("rst_mid_timer", 0, 0, 0, 0, 0);
        #1;
        pop_check();
        cyc(1);
        rst = 1'b0;
        push("after_rst_timer", 0, 0, 0, 0, 0);
        cyc(1);
        pop_check();

        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
